// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: decode-side control and output, plus the synchronous instruction ROM port.
// The master side is the fetch unit; the slave side is the surrounding pipeline/ROM.
interface instr_fetch_if #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 32
);
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_en, imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the fetch PC, reads a 1-cycle-latency ROM and
// buffers returned words in a 2-entry skid FIFO; redirects flush all wrong-path state.
module instr_fetch #(
  parameter int              PC_W      = 5,
  parameter int              INSTR_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  instr_fetch_if.master  bus
);

  localparam logic [2:0] CNT_MAX = 3'(BUF_DEPTH);

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    issue_pc;
  logic               inflight;
  logic [1:0]         count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [PC_W-1:0]    pc_buf    [2];
  logic [INSTR_W-1:0] instr_buf [2];

  logic               head_valid;
  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         occupancy;

  // Occupancy counts the word already in flight, so an issued read always has a slot.
  always_comb begin
    head_valid = (count != 2'd0);
    pop        = head_valid & ~bus.stall & ~bus.redirect;
    push       = inflight & ~bus.redirect;
    occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue      = reset_n & ~bus.redirect & (occupancy < CNT_MAX);
  end

  always_comb begin
    bus.imem_en   = issue;
    bus.imem_addr = fetch_pc;
    bus.out_valid = head_valid;
    bus.out_instr = head_valid ? instr_buf[rd_ptr] : '0;
    bus.out_pc    = head_valid ? pc_buf[rd_ptr]    : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      issue_pc <= RESET_PC;
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 1'b1;
        issue_pc <= fetch_pc;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf[wr_ptr]    <= issue_pc;
      instr_buf[wr_ptr] <= bus.imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && count == 2'd2));

  a_occupancy: assert property (@(posedge clk) disable iff (!reset_n)
    ({1'b0, count} + {2'b00, inflight}) <= 3'd2);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: a driver queues the expected PC/instruction
// stream at each restart, and a negedge monitor checks outputs against it.
module tb_instr_fetch;

  localparam int PC_W    = 5;
  localparam int INSTR_W = 32;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(5'd0), .BUF_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [INSTR_W-1:0] rom [32];

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  exp_t        q[$];
  logic [PC_W-1:0] next_pc;

  int unsigned     since;
  logic [PC_W-1:0] fptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic restart(input logic [PC_W-1:0] pc);
    q.delete();
    next_pc = pc;
  endtask

  task automatic top_up();
    while (q.size() < 40) begin
      q.push_back('{pc: next_pc, instr: rom[next_pc]});
      next_pc = next_pc + 1'b1;
    end
  endtask

  task automatic do_cycle(input logic st, input logic rd, input logic [PC_W-1:0] tgt);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = tgt;
    @(posedge clk);
    #1;
    if (rd) restart(tgt);
    top_up();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0);
  endtask

  task automatic pulse_reset();
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc",    32'(bus.out_pc),    32'd0);
    check("rst_out_instr", bus.out_instr,      32'd0);
    check("rst_imem_en",   32'(bus.imem_en),   32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    @(posedge clk);
    #1;
    restart(5'd0);
    top_up();
    reset_n = 1'b1;
  endtask

  // Refill takes two edges, after which the buffer never runs dry until the next restart.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      since = 0;
      fptr  = 5'd0;
    end else if (bus.redirect) begin
      since = 0;
      fptr  = bus.redirect_pc;
    end else begin
      if (since < 2 || !bus.stall) fptr = fptr + 1'b1;
      if (since < 2) since++;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      automatic logic exp_valid = (since >= 2);
      automatic logic exp_en    = !bus.redirect && (since < 2 || !bus.stall);
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("imem_en",   32'(bus.imem_en),   32'(exp_en));
      if (exp_en) check("imem_addr", 32'(bus.imem_addr), 32'(fptr));
      if (exp_valid) begin
        if (q.size() == 0) begin
          check("scoreboard_empty", 32'(q.size()), 32'd1);
        end else begin
          check("out_pc",    32'(bus.out_pc), 32'(q[0].pc));
          check("out_instr", bus.out_instr,   q[0].instr);
          if (!bus.stall && !bus.redirect) void'(q.pop_front());
        end
      end else begin
        check("idle_out_pc",    32'(bus.out_pc), 32'd0);
        check("idle_out_instr", bus.out_instr,   32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(i));
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rdata  = '0;
    #1;
    check("init_out_valid", 32'(bus.out_valid), 32'd0);
    check("init_imem_en",   32'(bus.imem_en),   32'd0);
    check("init_imem_addr", 32'(bus.imem_addr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    restart(5'd0);
    top_up();
    reset_n = 1'b1;

    idle(6);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, '0);
    idle(4);
    do_cycle(1'b0, 1'b1, 5'd20);
    idle(5);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, '0);
    do_cycle(1'b1, 1'b1, 5'd12);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, '0);
    idle(4);
    do_cycle(1'b0, 1'b1, 5'd28);
    idle(9);
    do_cycle(1'b0, 1'b1, 5'd3);
    do_cycle(1'b0, 1'b1, 5'd9);
    idle(5);
    pulse_reset();
    idle(8);

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        pulse_reset();
      end else begin
        do_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 5'($urandom_range(0, 31)));
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
